// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared FSM state type, accumulator sizing and
// saturating arithmetic helpers for the tensor MAC blocks.
package tensor_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_e;

  // Helpers work on a fixed wide carrier; callers slice the result.
  localparam int MAX_W = 256;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // a + b clamped to 2^w - 1.
  function automatic wide_t sat_add(
    input wide_t a,
    input wide_t b,
    input int    w
  );
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    if (s > lim) return lim[MAX_W-1:0];
    return s[MAX_W-1:0];
  endfunction

  // (v >> sh) clamped to 2^dw - 1.
  function automatic wide_t sat_out(
    input wide_t v,
    input int    sh,
    input int    dw
  );
    wide_t s;
    wide_t lim;
    s   = v >> sh;
    lim = (wide_t'(1) << dw) - wide_t'(1);
    if (s > lim) return lim;
    return s;
  endfunction

endpackage

// File: rtl/tensor_mac_array_if.sv
// tensor_mac_array_if: control, operand-beat and result-row handshakes.
// master drives start/operands/out_ready; slave returns ready/rows/status.
interface tensor_mac_array_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8
);

  logic                           start;
  logic                           accumulate;
  logic                           in_valid;
  logic                           in_ready;
  logic [N-1:0][DATA_WIDTH-1:0]   a_col;
  logic [N-1:0][DATA_WIDTH-1:0]   b_row;
  logic                           out_valid;
  logic                           out_ready;
  logic [N-1:0][DATA_WIDTH-1:0]   out_row;
  logic                           out_last;
  logic                           busy;
  logic                           done;

  modport master (
    output start, accumulate, in_valid,
    output a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row,
    input  out_last, busy, done
  );

  modport slave (
    input  start, accumulate, in_valid,
    input  a_col, b_row, out_ready,
    output in_ready, out_valid, out_row,
    output out_last, busy, done
  );

endinterface

// File: rtl/tensor_mac_pe.sv
// tensor_mac_pe: one accumulator cell; clr zeroes, en adds a*b saturating.
// Ports: clk, rst (async high), clr, en, a, b in; acc out.
module tensor_mac_pe
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = acc_width(32, 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [2*DATA_WIDTH-1:0]   prod;
  wide_t                     sum_full;
  logic [MAX_W-ACC_WIDTH-1:0] sum_unused;

  assign prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

  assign sum_full = sat_add(wide_t'(acc), wide_t'(prod), ACC_WIDTH);

  assign sum_unused = sum_full[MAX_W-1:ACC_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_full[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tensor_mac_array.sv
// tensor_mac_array: sequential NxN outer-product MAC with saturated row drain.
// Ports: clk, rst (async high), bus (tensor_mac_array_if.slave).
module tensor_mac_array
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8,
  parameter int FRAC_SHIFT = 8,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, N)
) (
  input logic               clk,
  input logic               rst,
  tensor_mac_array_if.slave bus
);

  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   r_q, r_d;
  logic            done_q, done_d;
  logic            clr;
  logic            beat;

  logic [ACC_WIDTH-1:0] acc [N][N];

  // Ready/valid depend only on registered state.
  assign beat = (state_q == LOAD) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    clr     = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          k_d     = '0;
          clr     = !bus.accumulate;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          k_d = k_q + CW'(1);
          if (k_q == LAST) begin
            state_d = DRAIN;
            k_d     = '0;
            r_d     = '0;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          r_d = r_q + CW'(1);
          if (r_q == LAST) begin
            state_d = IDLE;
            r_d     = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      tensor_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (beat),
        .a   (bus.a_col[i]),
        .b   (bus.b_row[j]),
        .acc (acc[i][j])
      );
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_last  = (state_q == DRAIN) && (r_q == LAST);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

  wide_t                       so;
  logic [MAX_W-DATA_WIDTH-1:0] row_unused;

  // Row is forced to zero outside DRAIN so idle/reset outputs stay low.
  always_comb begin
    bus.out_row = '0;
    row_unused  = '0;
    so          = '0;
    for (int j = 0; j < N; j++) begin
      so = sat_out(wide_t'(acc[r_q][j]), FRAC_SHIFT, DATA_WIDTH);
      row_unused = row_unused | so[MAX_W-1:DATA_WIDTH];
      if (state_q == DRAIN) begin
        bus.out_row[j] = so[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_tensor_mac_array.sv
// tb_tensor_mac_array: table-driven runs with a row scoreboard plus
// hand-written reset-mid-load and reset-value sequences.
module tb_tensor_mac_array;

  localparam int DW = 32;
  localparam int N  = 8;

  typedef logic [N-1:0][DW-1:0] row_t;

  typedef struct {
    row_t row;
    logic last;
  } exp_t;

  typedef struct {
    string name;
    int    a_kind;
    bit    acc;
    bit    stall;
    bit    disturb;
    bit    exp_ones;
    int    mult;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tensor_mac_array_if #(.DATA_WIDTH(DW), .N(N)) bus ();

  tensor_mac_array #(
    .DATA_WIDTH (DW),
    .N          (N),
    .FRAC_SHIFT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[9];

  task automatic chk(
    input string              nm,
    input logic [N*DW-1:0]    act,
    input logic [N*DW-1:0]    exp
  );
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_beat(input int a_kind, input int k);
    for (int i = 0; i < N; i++) begin
      if (a_kind == 1) begin
        bus.a_col[i] = '1;
        bus.b_row[i] = '1;
      end else begin
        bus.a_col[i] = (i == k) ? DW'(256) : '0;
        bus.b_row[i] = DW'(8 * k + i);
      end
    end
  endtask

  function automatic row_t exp_row(input bit ones, input int mult, input int i);
    row_t r;
    for (int j = 0; j < N; j++)
      r[j] = ones ? '1 : DW'((8 * i + j) * mult);
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    int   k;
    int   rows;
    int   cyc;
    bit   vld;
    bit   rdy;
    bit   have_prev;
    row_t prev_row;
    logic prev_last;
    exp_t e;
    @(negedge clk);
    chk({v.name, " idle busy"}, bus.busy, 0);
    bus.start      = 1'b1;
    bus.accumulate = v.acc;
    for (int i = 0; i < N; i++)
      sbq.push_back('{row: exp_row(v.exp_ones, v.mult, i), last: (i == N - 1)});
    @(negedge clk);
    bus.start = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      vld = v.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.in_valid = vld;
      set_beat(v.a_kind, k);
      if (v.disturb) bus.start = 1'b1;
      if (vld && bus.in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk({v.name, " beats"}, k, N);
    if (!v.stall) chk({v.name, " beat cycles"}, cyc, N);
    chk({v.name, " latency out_valid"}, bus.out_valid, 1);
    rows      = 0;
    cyc       = 0;
    have_prev = 0;
    prev_row  = '0;
    prev_last = 1'b0;
    while (rows < N && cyc < 200) begin
      rdy = v.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.out_ready = rdy;
      if (v.disturb) bus.start = 1'b1;
      if (have_prev) begin
        chk($sformatf("%s stall row%0d", v.name, rows), bus.out_row, prev_row);
        chk($sformatf("%s stall last%0d", v.name, rows), bus.out_last, prev_last);
      end
      if (rdy && bus.out_valid) begin
        if (sbq.size() == 0) begin
          chk($sformatf("%s sb empty row%0d", v.name, rows), 0, 1);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("%s row%0d", v.name, rows), bus.out_row, e.row);
          chk($sformatf("%s last%0d", v.name, rows), bus.out_last, e.last);
        end
        rows++;
        have_prev = 0;
      end else begin
        prev_row  = bus.out_row;
        prev_last = bus.out_last;
        have_prev = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk({v.name, " rows"}, rows, N);
    if (!v.stall) chk({v.name, " drain cycles"}, cyc, N);
    chk({v.name, " done pulse"}, bus.done, 1);
    chk({v.name, " busy after"}, bus.busy, 0);
    @(negedge clk);
    chk({v.name, " done low"}, bus.done, 0);
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.accumulate = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.a_col      = '0;
    bus.b_row      = '0;
    vecs[0] = '{"ident",      0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{"accum",      0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[2] = '{"reclear",    0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[3] = '{"sat",        1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{"sat_acc",    1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{"bkpr",       0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[6] = '{"bkpr_acc",   0, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[7] = '{"disturb",    0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[8] = '{"dist_stall", 0, 1'b1, 1'b1, 1'b1, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk("rst in_ready",  bus.in_ready,  0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_last",  bus.out_last,  0);
    chk("rst busy",      bus.busy,      0);
    chk("rst done",      bus.done,      0);
    chk("rst out_row",   bus.out_row,   0);
    rst = 1'b0;

    for (int t = 0; t < 9; t++) run_op(vecs[t]);

    // Reset in the middle of LOAD, then accumulate onto what must be zero.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.accumulate = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_beat(0, k);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("midload busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst in_ready",  bus.in_ready,  0);
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst busy",      bus.busy,      0);
    chk("midrst done",      bus.done,      0);
    chk("midrst out_row",   bus.out_row,   0);
    @(negedge clk);
    rst = 1'b0;
    run_op('{"post_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
